// File: rtl/vga_seq_pkg.sv
// Shared definitions for the VGA update sequencer: port map, FSM states, snapshot layout.
// Also holds the helper that turns a snapshot and write index into the byte for that port.
package vga_seq_pkg;

  localparam logic [7:0] PORT_AGNO_H   = 8'h04;
  localparam logic [7:0] PORT_AGNO_L   = 8'h05;
  localparam logic [7:0] PORT_MESSE_H  = 8'h06;
  localparam logic [7:0] PORT_MESSE_L  = 8'h07;
  localparam logic [7:0] PORT_GIORNO_H = 8'h08;
  localparam logic [7:0] PORT_GIORNO_L = 8'h09;
  localparam logic [7:0] PORT_HORO_H   = 8'h0a;
  localparam logic [7:0] PORT_HORO_L   = 8'h0b;
  localparam logic [7:0] PORT_MORO_H   = 8'h0c;
  localparam logic [7:0] PORT_MORO_L   = 8'h0d;
  localparam logic [7:0] PORT_SORO_H   = 8'h0e;
  localparam logic [7:0] PORT_SORO_L   = 8'h0f;
  localparam logic [7:0] PORT_HRUN_H   = 8'h10;
  localparam logic [7:0] PORT_HRUN_L   = 8'h11;
  localparam logic [7:0] PORT_MRUN_H   = 8'h12;
  localparam logic [7:0] PORT_MRUN_L   = 8'h13;
  localparam logic [7:0] PORT_SRUN_H   = 8'h14;
  localparam logic [7:0] PORT_SRUN_L   = 8'h15;
  localparam logic [7:0] PORT_FLAGS    = 8'h16;
  localparam logic [7:0] PORT_CURSOR   = 8'h17;
  localparam logic [7:0] PORT_PROG     = 8'h18;
  localparam logic [7:0] PORT_HS       = 8'h19;

  localparam int         NUM_DATA_WRITES = 21;
  localparam logic [4:0] IDX_LAST        = 5'(NUM_DATA_WRITES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_VB,
    ST_COMMIT,
    ST_RELEASE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] agno;
    logic [7:0] messe;
    logic [7:0] giorno;
    logic [7:0] h_oro;
    logic [7:0] m_oro;
    logic [7:0] s_oro;
    logic [7:0] h_run;
    logic [7:0] m_run;
    logic [7:0] s_run;
    logic       am_pm;
    logic       formato;
    logic [2:0] cursor;
    logic [7:0] prog;
  } snap_t;

  // BCD fields go out one digit per port, tens first.
  function automatic logic [7:0] snap_byte(input snap_t s, input logic [4:0] idx);
    snap_byte = 8'h00;
    case (idx)
      5'd0:  snap_byte = {4'h0, s.agno[7:4]};
      5'd1:  snap_byte = {4'h0, s.agno[3:0]};
      5'd2:  snap_byte = {4'h0, s.messe[7:4]};
      5'd3:  snap_byte = {4'h0, s.messe[3:0]};
      5'd4:  snap_byte = {4'h0, s.giorno[7:4]};
      5'd5:  snap_byte = {4'h0, s.giorno[3:0]};
      5'd6:  snap_byte = {4'h0, s.h_oro[7:4]};
      5'd7:  snap_byte = {4'h0, s.h_oro[3:0]};
      5'd8:  snap_byte = {4'h0, s.m_oro[7:4]};
      5'd9:  snap_byte = {4'h0, s.m_oro[3:0]};
      5'd10: snap_byte = {4'h0, s.s_oro[7:4]};
      5'd11: snap_byte = {4'h0, s.s_oro[3:0]};
      5'd12: snap_byte = {4'h0, s.h_run[7:4]};
      5'd13: snap_byte = {4'h0, s.h_run[3:0]};
      5'd14: snap_byte = {4'h0, s.m_run[7:4]};
      5'd15: snap_byte = {4'h0, s.m_run[3:0]};
      5'd16: snap_byte = {4'h0, s.s_run[7:4]};
      5'd17: snap_byte = {4'h0, s.s_run[3:0]};
      5'd18: snap_byte = {3'b000, s.am_pm, 3'b000, s.formato};
      5'd19: snap_byte = {5'b00000, s.cursor};
      5'd20: snap_byte = s.prog;
      default: snap_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/vga_bus_arbiter.sv
// Fixed-priority port bus mux (CPU over sequencer) with registered outputs, 1-cycle latency.
// grant tells the sequencer its request was taken this cycle; otherwise it must retry.
module vga_bus_arbiter
  import vga_seq_pkg::*;
(
  input  logic       reloj_interno,
  input  logic       reset_interno,
  input  logic       cpu_strobe,
  input  logic [7:0] cpu_id,
  input  logic [7:0] cpu_dato,
  input  logic       seq_req,
  input  logic [7:0] seq_id,
  input  logic [7:0] seq_dato,
  output logic       grant,
  output logic [7:0] id_port,
  output logic [7:0] dato,
  output logic       write_strobe
);

  assign grant = seq_req & ~cpu_strobe;

  // Address/data hold their last value when nobody writes.
  always_ff @(posedge reloj_interno or posedge reset_interno) begin
    if (reset_interno) begin
      id_port      <= 8'h00;
      dato         <= 8'h00;
      write_strobe <= 1'b0;
    end else begin
      write_strobe <= cpu_strobe | seq_req;
      if (cpu_strobe) begin
        id_port <= cpu_id;
        dato    <= cpu_dato;
      end else if (seq_req) begin
        id_port <= seq_id;
        dato    <= seq_dato;
      end
    end
  end

endmodule

// File: rtl/vga_update_sequencer.sv
// Snapshots clock/date/chrono/cursor state on start, streams it to VGA ports 0x04..0x18,
// then commits on port 0x19 at the next vsync edge; the CPU always wins the shared bus.
module vga_update_sequencer
  import vga_seq_pkg::*;
#(
  parameter logic [7:0] HS_VALUE         = 8'h01,
  parameter bit         VSYNC_ACTIVE_LOW = 1'b1,
  parameter bit         WAIT_VBLANK      = 1'b1
) (
  input  logic       reloj_interno,
  input  logic       reset_interno,
  input  logic       start,
  input  logic [7:0] agno,
  input  logic [7:0] messe,
  input  logic [7:0] giorno,
  input  logic [7:0] h_oro,
  input  logic [7:0] m_oro,
  input  logic [7:0] s_oro,
  input  logic [7:0] h_run,
  input  logic [7:0] m_run,
  input  logic [7:0] s_run,
  input  logic       am_pm,
  input  logic       formato,
  input  logic [2:0] cursor,
  input  logic [7:0] prog,
  input  logic       vsync_in,
  input  logic [7:0] cpu_id,
  input  logic [7:0] cpu_dato,
  input  logic       cpu_strobe,
  output logic [7:0] id_port,
  output logic [7:0] dato,
  output logic       write_strobe,
  output logic       busy,
  output logic       done
);

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  snap_t      snap_q;
  logic       capture;
  logic       seq_req;
  logic [7:0] seq_id;
  logic [7:0] seq_dato;
  logic       grant;
  logic       vs_act, vs_prev, vs_edge;

  // Edge into the sync pulse; a pulse already running when WAIT_VB is entered never qualifies.
  assign vs_act  = VSYNC_ACTIVE_LOW ? ~vsync_in : vsync_in;
  assign vs_edge = vs_act & ~vs_prev;

  always_ff @(posedge reloj_interno or posedge reset_interno) begin
    if (reset_interno) begin
      state_q <= ST_IDLE;
      idx_q   <= 5'd0;
      snap_q  <= '0;
      vs_prev <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vs_prev <= vs_act;
      busy    <= (state_d != ST_IDLE);
      done    <= (state_q == ST_DONE);
      if (capture) begin
        snap_q <= '{agno: agno, messe: messe, giorno: giorno,
                    h_oro: h_oro, m_oro: m_oro, s_oro: s_oro,
                    h_run: h_run, m_run: m_run, s_run: s_run,
                    am_pm: am_pm, formato: formato, cursor: cursor, prog: prog};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    capture  = 1'b0;
    seq_req  = 1'b0;
    seq_id   = PORT_AGNO_H + {3'b000, idx_q};
    seq_dato = snap_byte(snap_q, idx_q);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          capture = 1'b1;
          idx_d   = 5'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        seq_req = 1'b1;
        if (grant) begin
          if (idx_q == IDX_LAST) begin
            state_d = WAIT_VBLANK ? ST_WAIT_VB : ST_COMMIT;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      ST_WAIT_VB: begin
        if (vs_edge) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        seq_req  = 1'b1;
        seq_id   = PORT_HS;
        seq_dato = HS_VALUE;
        if (grant) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        seq_req  = 1'b1;
        seq_id   = PORT_HS;
        seq_dato = 8'h00;
        if (grant) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  vga_bus_arbiter u_arb (
    .reloj_interno (reloj_interno),
    .reset_interno (reset_interno),
    .cpu_strobe    (cpu_strobe),
    .cpu_id        (cpu_id),
    .cpu_dato      (cpu_dato),
    .seq_req       (seq_req),
    .seq_id        (seq_id),
    .seq_dato      (seq_dato),
    .grant         (grant),
    .id_port       (id_port),
    .dato          (dato),
    .write_strobe  (write_strobe)
  );

endmodule

// File: doc/vga_update_sequencer.md
Name: vga_update_sequencer

Overview:
- Takes one snapshot of the clock/date/chronometer/cursor state on a start pulse and streams it into the VGA controller's port-mapped provisional registers as 21 single-cycle writes (ports 0x04..0x18).
- Waits for the start of vertical sync, then issues the handshake commit on port 0x19 so the display switches to the new values without tearing.
- Shares the single port bus with the CPU; CPU writes always take priority.

Parameters:
- HS_VALUE, 8'h01, data written to port 0x19 to commit; 8'h00 is written the next bus slot to release it.
- VSYNC_ACTIVE_LOW, 1, polarity of vsync_in; 1 means the sync pulse is low.
- WAIT_VBLANK, 1, 0 skips the vsync wait and commits immediately after the last data write.

Ports:
- reloj_interno  in  1  system clock
- reset_interno  in  1  reset
- start  in  1  one-cycle request; sampled only in IDLE
- agno, messe, giorno  in  8 each  BCD date (hi nibble = tens)
- h_oro, m_oro, s_oro  in  8 each  BCD time
- h_run, m_run, s_run  in  8 each  BCD chronometer
- am_pm, formato  in  1 each  12h flags
- cursor  in  3  cursor position
- prog  in  8  programming-target key code
- vsync_in  in  1  vsincro from the sync generator, same clock domain
- cpu_id, cpu_dato  in  8 each  CPU port address and data
- cpu_strobe  in  1  CPU write strobe
- id_port, dato  out  8 each  arbitrated port bus to the VGA controller
- write_strobe  out  1  arbitrated strobe
- busy  out  1  high from accepted start until DONE
- done  out  1  one-cycle pulse after the release write

Behaviour:
- Reset reset_interno, asynchronous, active-high.
- On reset, all outputs are 0, the FSM is in IDLE, the index is 0, and the snapshot registers are 0.
- States: IDLE, SEND, WAIT_VB, COMMIT, RELEASE, DONE.
- IDLE:
  - On start, capture all snapshot inputs into internal registers and go to SEND with idx=0. busy rises the next cycle.
  - start in any other state is ignored (no queuing).
- SEND: each granted slot issues port 0x04+idx, then idx increments. After idx=20 is issued:
  - go to WAIT_VB if WAIT_VBLANK=1;
  - otherwise go to COMMIT.
- Data mapping, always in dato[3:0] with upper nibble 0 unless stated:
  - 04/05 agno hi/lo
  - 06/07 messe hi/lo
  - 08/09 giorno hi/lo
  - 0a/0b h_oro hi/lo
  - 0c/0d m_oro hi/lo
  - 0e/0f s_oro hi/lo
  - 10/11 h_run hi/lo
  - 12/13 m_run hi/lo
  - 14/15 s_run hi/lo
  - 16: {3'b0, am_pm, 3'b0, formato}
  - 17: {5'b0, cursor}
  - 18: prog (full 8 bits)
- WAIT_VB:
  - One-flop edge detector on vsync_in; the active edge is the transition into the sync pulse (1->0 when VSYNC_ACTIVE_LOW=1).
  - The edge must occur after entering WAIT_VB. An edge in the entry cycle counts; a pulse already in progress does not.
  - On the edge, go to COMMIT.
- COMMIT: issue port 0x19 with dato=HS_VALUE, then go to RELEASE.
- RELEASE: issue port 0x19 with dato=8'h00, then go to DONE.
- DONE: done=1 for one cycle, busy falls, return to IDLE.
- Arbitration:
  - In a cycle with cpu_strobe=1, the next-cycle bus carries cpu_id/cpu_dato with write_strobe=1.
  - The sequencer's slot is not consumed: idx and state hold, and the FSM retries in the following cycle.
- Bus outputs are registered, giving 1-cycle latency for both sources.
  - In cycles with no write, write_strobe=0 and id_port/dato hold their last value.
- Every write_strobe pulse is exactly one cycle. Back-to-back writes from the same or different sources are legal.
- Minimum sequence length with no CPU traffic and WAIT_VBLANK=0 is 21+2 write cycles plus DONE, i.e. start to done = 25 cycles.
- Reset mid-sequence: abort immediately, no commit write, busy=0, done not asserted.
  - The VGA controller keeps its previous display values because no handshake was written.
- CPU writes during WAIT_VB pass through unchanged.

Decomposition:
- Package vga_seq_pkg:
  - port address constants PORT_AGNO_H=8'h04 .. PORT_PROG=8'h18, PORT_HS=8'h19;
  - NUM_DATA_WRITES=21;
  - state enum encoding.
- Sub-module vga_bus_arbiter: the two-source fixed-priority mux plus output registers, with a grant/stall signal back to the FSM. The FSM, snapshot registers and idx-to-data mux stay in the top.

Test Plan:
- Start with agno=8'h16, messe=8'h05, giorno=8'h22, h_oro=8'h13, WAIT_VBLANK=0, no CPU traffic -> 23 consecutive strobes: (04,01),(05,06),(06,00),(07,05),(08,02),(09,02),(0a,01),(0b,03)...(19,01),(19,00); done exactly 25 cycles after start.
- cpu_strobe held for 3 cycles (id 8'h30, dato 8'hAA) during SEND at idx=5 -> 3 CPU writes appear on the bus, then port 0x09 resumes; no port is skipped or duplicated.
- WAIT_VBLANK=1, vsync_in already low on entry, later goes high then low -> no commit during the first pulse; (19,HS_VALUE) appears 1 cycle after the later 1->0 edge.
- Reset asserted at idx=10 -> outputs 0 asynchronously; no 0x19 write; a new start afterwards produces a full sequence starting at port 0x04.
- start pulsed again while busy with changed inputs -> ignored; the data streamed is the originally captured snapshot.
- am_pm=1, formato=1, cursor=3'd5, prog=8'h2B -> writes (16,8'h11), (17,8'h05), (18,8'h2B).
